// File: rtl/pad_input_filter_pkg.sv
// Shared types and constants for the pad input filter and related pad inputs.
//   filt_state_t      : debounce FSM states
//   DEFAULT_CNT_WIDTH : default debounce counter / threshold width
//   cnt_t             : counter type at the default width
package pad_input_filter_pkg;

  localparam int DEFAULT_CNT_WIDTH = 16;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } filt_state_t;

  typedef logic [DEFAULT_CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/pad_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads RESET_VALUE into every flop
//   d_i    : asynchronous input
//   q_o    : synchronised output (last stage)
module pad_sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {STAGES{RESET_VALUE}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pad_input_filter.sv
// Input pad companion: synchronises an off-chip pad into clk_i, optionally
// debounces it, and produces a clean level plus one-cycle rise/fall pulses.
//   clk_i             : block clock
//   rst_ni            : asynchronous active-low reset
//   pad_io            : physical pad, sampled only (driven high-Z)
//   pad_attributes_i  : technology attributes, unused in this generic model
//   filter_en_i       : 1 = debounce active, 0 = bypass
//   debounce_cycles_i : stability threshold N
//   pad_sync_o        : raw synchronised pad value
//   level_o           : filtered level
//   rise_o / fall_o   : one-cycle pulses on level_o 0->1 / 1->0
module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int   PADATTR     = 16,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  inout  wire                                    pad_io,
  input  logic [((PADATTR > 0) ? PADATTR : 1)-1:0] pad_attributes_i,
  input  logic                                   filter_en_i,
  input  logic [CNT_WIDTH-1:0]                   debounce_cycles_i,
  output logic                                   pad_sync_o,
  output logic                                   level_o,
  output logic                                   rise_o,
  output logic                                   fall_o
);

  localparam int SYNC_RND = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  filt_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_n, level_d;
  logic                 sync;
  logic                 unused_attr;

  assign pad_io      = 1'bz;
  assign unused_attr = ^pad_attributes_i;

  pad_sync_chain #(
    .STAGES      (SYNC_RND),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_io),
    .q_o    (sync)
  );

  // State register (FSM, counter, level and its delayed copy)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= RESET_VALUE;
      level_d <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_n;
      level_d <= level_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!filter_en_i) begin
      state_d = STABLE;
    end else begin
      case (state_q)
        STABLE:   if (sync != level_q) state_d = SETTLING;
        SETTLING: if ((sync == level_q) || (cnt_q >= debounce_cycles_i)) state_d = STABLE;
        default:  state_d = STABLE;
      endcase
    end
  end

  // Counter and level updates; the counter only advances while settling
  // and saturates rather than wrapping.
  always_comb begin
    level_n = level_q;
    cnt_d   = '0;
    if (!filter_en_i) begin
      level_n = sync;
    end else if ((state_q == SETTLING) && (sync != level_q)) begin
      if (cnt_q >= debounce_cycles_i) begin
        level_n = sync;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  assign pad_sync_o = sync;
  assign level_o    = level_q;
  assign rise_o     = level_q & ~level_d;
  assign fall_o     = ~level_q & level_d;

endmodule

// File: tb/tb_pad_input_filter.sv
module tb_pad_input_filter;
  import pad_input_filter_pkg::*;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pad_drv = 1'b1;
  wire         pad_w;
  logic [15:0] attr = '0;
  logic        en = 1'b0;
  cnt_t        n_thr = '0;
  logic        pad_sync, level, rise, fall;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  assign pad_w = pad_drv;

  always #5 clk = ~clk;

  pad_input_filter #(
    .PADATTR     (16),
    .SYNC_STAGES (SYNC),
    .CNT_WIDTH   (16),
    .RESET_VALUE (1'b0)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .pad_io            (pad_w),
    .pad_attributes_i  (attr),
    .filter_en_i       (en),
    .debounce_cycles_i (n_thr),
    .pad_sync_o        (pad_sync),
    .level_o           (level),
    .rise_o            (rise),
    .fall_o            (fall)
  );

  // Behavioural model: the pad is seen SYNC edges late; the filtered level
  // flips once sync has disagreed with it for N+2 consecutive cycles
  // (bypass: copies sync one edge later). Pulses mark level changes.
  logic [SYNC-1:0] m_sh = '0;
  logic m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;

  initial forever begin
    logic s, old;
    int   c;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_sh = '0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      s   = m_sh[SYNC-1];
      old = m_level;
      if (!en) begin
        m_level = s;
        m_run   = 0;
      end else if (s == m_level) begin
        m_run = 0;
      end else begin
        m_run = m_run + 1;
        c = m_run - 2;
        if (c > 65535) c = 65535;
        if (m_run >= 2 && c >= int'(n_thr)) begin
          m_level = s;
          m_run   = 0;
        end
      end
      m_rise = m_level & ~old;
      m_fall = ~m_level & old;
      m_sh   = {m_sh[SYNC-2:0], pad_drv};
    end
  end

  // Per-cycle compare of all outputs against the model
  initial forever begin
    @(negedge clk);
    cyc++;
    tests++;
    if ({pad_sync, level, rise, fall} !== {m_sh[SYNC-1], m_level, m_rise, m_fall}) begin
      fails++;
      $display("FAIL model_cmp cycle %0d: got sync/level/rise/fall=%b%b%b%b expected %b%b%b%b",
               cyc, pad_sync, level, rise, fall, m_sh[SYNC-1], m_level, m_rise, m_fall);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // Reset with pad high
    tick(3);
    check("rst_sync", pad_sync, 1'b0);
    check("rst_level", level, 1'b0);
    check("rst_rise", rise, 1'b0);
    check("rst_fall", fall, 1'b0);
    rst_n = 1'b1;
    tick(1); check("rel_sync1", pad_sync, 1'b0); check("rel_rise1", rise, 1'b0);
    tick(1); check("rel_sync2", pad_sync, 1'b1); check("rel_level2", level, 1'b0);
    tick(1); check("rel_level3", level, 1'b1); check("rel_rise3", rise, 1'b1);
    tick(1); check("rel_rise4", rise, 1'b0);

    // Bypass 0 -> 1
    pad_drv = 1'b0; tick(4);
    check("byp_low", level, 1'b0);
    pad_drv = 1'b1;
    tick(2); check("byp_sync2", pad_sync, 1'b1); check("byp_level2", level, 1'b0);
    tick(1); check("byp_level3", level, 1'b1); check("byp_rise3", rise, 1'b1);
    tick(1); check("byp_rise4", rise, 1'b0);

    // Filter N=4: 5-cycle pulse rejected, sustained high accepted
    pad_drv = 1'b0; tick(4);
    en = 1'b1; n_thr = 16'd4;
    pad_drv = 1'b1; tick(5); pad_drv = 1'b0; tick(12);
    check("n4_short", level, 1'b0);
    pad_drv = 1'b1;
    tick(7); check("n4_before", level, 1'b0);
    tick(1); check("n4_level", level, 1'b1); check("n4_rise", rise, 1'b1);
    tick(1); check("n4_rise_end", rise, 1'b0);

    // Filter N=10: glitch train never settles
    n_thr = 16'd10;
    for (int i = 0; i < 6; i++) begin
      pad_drv = 1'b0; tick(3);
      pad_drv = 1'b1; tick(1);
    end
    tick(4);
    check("glitch_level", level, 1'b1);

    // Threshold lowered mid-settle (cnt = 7)
    n_thr = 16'd20; pad_drv = 1'b0;
    tick(10); check("thr_hold", level, 1'b1);
    n_thr = 16'd3;
    tick(1); check("thr_level", level, 1'b0); check("thr_fall", fall, 1'b1);

    // Filter disabled mid-settle
    n_thr = 16'd20; pad_drv = 1'b1;
    tick(10); check("dis_hold", level, 1'b0);
    en = 1'b0;
    tick(1); check("dis_level", level, 1'b1); check("dis_rise", rise, 1'b1);
    en = 1'b1;
    tick(3); check("en_norise", rise, 1'b0); check("en_level", level, 1'b1);

    // Max threshold: saturating settle
    en = 1'b0; pad_drv = 1'b0; tick(4);
    check("max_pre", level, 1'b0);
    en = 1'b1; n_thr = 16'hFFFF; pad_drv = 1'b1;
    tick(65538); check("max_before", level, 1'b0);
    tick(1); check("max_level", level, 1'b1); check("max_rise", rise, 1'b1);

    // Asynchronous reset mid-settle
    pad_drv = 1'b0; tick(50);
    #2 rst_n = 1'b0;
    #1 check("async_level", level, 1'b0);
    check("async_fall", fall, 1'b0);
    tick(2); rst_n = 1'b1;
    tick(5); check("post_rst_level", level, 1'b0); check("post_rst_fall", fall, 1'b0);

    // Randomised runs against the model
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) n_thr = cnt_t'($urandom_range(0, 8));
      pad_drv = ~pad_drv;
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    end
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
